// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared addresses, CON bit positions and TX states for uart_ctrl
package uart_pkg;
    localparam logic [31:0] UART_ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] UART_ADDR_CON = 32'h4000_0020;

    localparam int CON_RX_IE    = 0;
    localparam int CON_TX_IE    = 1;
    localparam int CON_RX_AVAIL = 2;
    localparam int CON_TX_READY = 3;
    localparam int CON_RX_OVR   = 4;
    localparam int CON_LPBK     = 5;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_BUSY = 2'd2;
endpackage

// File: rtl/uart_ctrl_fifo.sv
// rtl/uart_ctrl_fifo.sv - byte FIFO for received data, DEPTH a power of two
module uart_ctrl_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - UART controller: status syncs, RX FIFO, TX holding reg/FSM, IRQ; optional UART_CTRL_LOOPBACK_EN
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int          RX_DEPTH = 4,
    parameter logic [31:0] ADDR_TXD = UART_ADDR_TXD,
    parameter logic [31:0] ADDR_RXD = UART_ADDR_RXD,
    parameter logic [31:0] ADDR_CON = UART_ADDR_CON
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        irq
);
    logic       rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
    logic       tx_s1_q, tx_s1_d, tx_s2_q, tx_s2_d;
    logic [1:0] state_q, state_d;
    logic [7:0] hold_q, hold_d, tx_data_q, tx_data_d;
    logic       hold_full_q, hold_full_d;
    logic       rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, rx_ovr_q, rx_ovr_d;
    logic       irq_q, irq_d;
    logic       lpbk;
    logic       wr_txd, wr_con, rd_rxd;
    logic       fifo_push, fifo_full, fifo_empty;
    logic [7:0] fifo_push_data, fifo_head;
    logic [31:0] con_val;
    logic       unused_wdata;

`ifdef UART_CTRL_LOOPBACK_EN
    logic lpbk_q, lpbk_d;
    assign lpbk = lpbk_q;
`else
    assign lpbk = 1'b0;
`endif

    assign unused_wdata = ^wdata[31:8];
    assign wr_txd = wr & (addr == ADDR_TXD);
    assign wr_con = wr & (addr == ADDR_CON);
    assign rd_rxd = rd & (addr == ADDR_RXD);

    always_comb begin
        rx_s1_d = rx_status;
        rx_s2_d = rx_s1_q;
        rx_s3_d = rx_s2_q;
        tx_s1_d = tx_status;
        tx_s2_d = tx_s1_q;
        state_d = state_q;
        hold_d = hold_q;
        hold_full_d = hold_full_q;
        tx_data_d = tx_data_q;
        rx_ie_d = rx_ie_q;
        tx_ie_d = tx_ie_q;
        rx_ovr_d = rx_ovr_q;
        fifo_push = rx_s2_q & ~rx_s3_q & ~lpbk;
        fifo_push_data = rx_data;
`ifdef UART_CTRL_LOOPBACK_EN
        lpbk_d = lpbk_q;
`endif
        case (state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
`ifdef UART_CTRL_LOOPBACK_EN
                    if (lpbk_q) begin
                        fifo_push = 1'b1;
                        fifo_push_data = hold_q;
                        hold_full_d = 1'b0;
                    end else
`endif
                    begin
                        state_d = TX_REQ;
                        tx_data_d = hold_q;
                        hold_full_d = 1'b0;
                    end
                end
            end
            TX_REQ:  if (tx_s2_q) state_d = TX_BUSY;
            TX_BUSY: if (!tx_s2_q) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
        if (wr_txd && !hold_full_q) begin
            hold_d = wdata[7:0];
            hold_full_d = 1'b1;
        end
        if (wr_con) begin
            rx_ie_d = wdata[CON_RX_IE];
            tx_ie_d = wdata[CON_TX_IE];
            if (wdata[CON_RX_OVR]) rx_ovr_d = 1'b0;
`ifdef UART_CTRL_LOOPBACK_EN
            lpbk_d = wdata[CON_LPBK];
`endif
        end
        // A fresh overrun outranks a simultaneous clear so the event is never lost.
        if (fifo_push && fifo_full && !rd_rxd) rx_ovr_d = 1'b1;
        irq_d = (rx_ie_q & ~fifo_empty) | (tx_ie_q & ~hold_full_q & (state_q == TX_IDLE));
    end

    uart_ctrl_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (rd_rxd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b0; rx_s2_q <= 1'b0; rx_s3_q <= 1'b0;
            tx_s1_q <= 1'b0; tx_s2_q <= 1'b0;
            state_q <= TX_IDLE;
            hold_q <= 8'h00; hold_full_q <= 1'b0; tx_data_q <= 8'h00;
            rx_ie_q <= 1'b0; tx_ie_q <= 1'b0; rx_ovr_q <= 1'b0;
            irq_q <= 1'b0;
`ifdef UART_CTRL_LOOPBACK_EN
            lpbk_q <= 1'b0;
`endif
        end else begin
            rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_s3_q <= rx_s3_d;
            tx_s1_q <= tx_s1_d; tx_s2_q <= tx_s2_d;
            state_q <= state_d;
            hold_q <= hold_d; hold_full_q <= hold_full_d; tx_data_q <= tx_data_d;
            rx_ie_q <= rx_ie_d; tx_ie_q <= tx_ie_d; rx_ovr_q <= rx_ovr_d;
            irq_q <= irq_d;
`ifdef UART_CTRL_LOOPBACK_EN
            lpbk_q <= lpbk_d;
`endif
        end
    end

    assign con_val = {26'b0, lpbk, rx_ovr_q, ~hold_full_q, ~fifo_empty, tx_ie_q, rx_ie_q};

    always_comb begin
        rdata = 32'h0;
        if (addr == ADDR_TXD)      rdata = {24'b0, hold_q};
        else if (addr == ADDR_RXD) rdata = fifo_empty ? 32'h0 : {24'b0, fifo_head};
        else if (addr == ADDR_CON) rdata = con_val;
    end

    assign tx_en   = (state_q == TX_REQ);
    assign tx_data = tx_data_q;
    assign irq     = irq_q;
endmodule
